// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory response block: MMIO map, target decode, read-lane helpers.
package dmem_pkg;

  localparam logic [15:0] MMIO_BASE     = 16'h8000;
  localparam int unsigned CON_DEPTH_DEF = 4;

  localparam logic [1:0] OFF_CYCLE   = 2'd0;
  localparam logic [1:0] OFF_CONSOLE = 2'd1;
  localparam logic [1:0] OFF_DONE    = 2'd2;
  localparam logic [1:0] OFF_SCRATCH = 2'd3;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_SRAM = 2'd1,
    TGT_MMIO = 2'd2
  } tgt_e;

  // Read request captured at the end of cycle N, consumed in cycle N+1.
  typedef struct packed {
    logic [3:0] re;
    logic       from_mmio;
  } rd_ctl_t;

  // Classify a request by the address top bit; no lanes enabled means no target.
  function automatic tgt_e tgt_decode(input logic a15, input logic access);
    if (!access) begin
      return TGT_NONE;
    end
    if (a15 == MMIO_BASE[15]) begin
      return TGT_MMIO;
    end
    return TGT_SRAM;
  endfunction

  // Expand per-byte read enables into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] re);
    return {{8{re[3]}}, {8{re[2]}}, {8{re[1]}}, {8{re[0]}}};
  endfunction

endpackage

// File: rtl/con_fifo.sv
// Console byte FIFO: head is presented while non-empty; a push to a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise it is dropped.
module con_fifo
  import dmem_pkg::*;
#(
  parameter  int unsigned DEPTH = CON_DEPTH_DEF,
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          vld_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic          drop_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop_i & ~empty;
  assign push_ok = push_i & (~full | pop_ok);

  assign drop_o  = push_i & full & ~pop_ok;
  assign full_o  = full;
  assign empty_o = empty;
  assign vld_o   = ~empty;
  assign count_o = count_q;
  // Gate the head with empty so the output reads 0 in reset and when idle.
  assign data_o  = empty ? 8'h00 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = PW'(wr_ptr_q + PW'(1));
    end
    if (pop_ok) begin
      rd_ptr_d = PW'(rd_ptr_q + PW'(1));
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = CW'(count_q + CW'(1));
      2'b01:   count_d = CW'(count_q - CW'(1));
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the FIFO regardless of stored data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only visible through count, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Core data-port responder: routes requests to the SRAM macro or a small MMIO
// block (cycle counter, console FIFO, done flag, scratch) with one-cycle reads.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int unsigned SRAM_AW   = 13,
  parameter int unsigned CON_DEPTH = CON_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [15:0]        dat_a,
  input  logic [3:0]         dat_we,
  input  logic [31:0]        dat_wd,
  input  logic [3:0]         dat_re,
  output logic [31:0]        dat_rd,
  output logic [SRAM_AW-1:0] sram_a,
  output logic               sram_ce,
  output logic [3:0]         sram_we,
  output logic [31:0]        sram_wd,
  input  logic [31:0]        sram_rd,
  output logic               con_vld,
  output logic [7:0]         con_data,
  input  logic               con_rdy,
  output logic               done,
  output logic [31:0]        done_code,
  output logic               err,
  output logic               ovf
);

  localparam int unsigned CNT_W = $clog2(CON_DEPTH + 1);

  logic       has_we, has_re, proto_err;
  tgt_e       tgt;
  logic [1:0] reg_off;
  logic       mmio_wr, mmio_rd;
  logic       unused_addr;

  assign has_we      = |dat_we;
  assign has_re      = |dat_re;
  assign proto_err   = has_we & has_re;
  assign tgt         = tgt_decode(dat_a[15], has_we | has_re);
  assign reg_off     = dat_a[3:2];
  assign mmio_wr     = (tgt == TGT_MMIO) & has_we;
  assign mmio_rd     = (tgt == TGT_MMIO) & has_re & ~proto_err;
  assign unused_addr = ^dat_a[1:0];

  // SRAM macro drive, valid in the request cycle itself.
  always_comb begin
    sram_a  = SRAM_AW'(dat_a[14:2]);
    sram_wd = dat_wd;
    sram_ce = 1'b0;
    sram_we = 4'h0;
    if (tgt == TGT_SRAM) begin
      sram_ce = 1'b1;
      sram_we = dat_we;
    end
  end

  logic             con_push, con_full, con_empty, con_drop;
  logic [CNT_W-1:0] con_count;

  assign con_push = mmio_wr & (reg_off == OFF_CONSOLE) & dat_we[0];

  con_fifo #(
    .DEPTH (CON_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (con_push),
    .data_i  (dat_wd[7:0]),
    .pop_i   (con_rdy),
    .data_o  (con_data),
    .vld_o   (con_vld),
    .full_o  (con_full),
    .empty_o (con_empty),
    .count_o (con_count),
    .drop_o  (con_drop)
  );

  logic [31:0] cyc_q, cyc_d;
  logic [31:0] scratch_q, scratch_d;
  logic        done_q, done_d;
  logic [31:0] done_code_q, done_code_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;
  logic [31:0] mmio_rdata_q, mmio_rdata_d;
  rd_ctl_t     rd_ctl_q, rd_ctl_d;

  // MMIO register updates and capture of the read for the following cycle.
  always_comb begin
    cyc_d        = 32'(cyc_q + 32'd1);
    scratch_d    = scratch_q;
    done_d       = done_q;
    done_code_d  = done_code_q;
    err_d        = err_q | proto_err;
    ovf_d        = ovf_q | con_drop;
    mmio_rdata_d = mmio_rdata_q;
    rd_ctl_d.re        = proto_err ? 4'h0 : dat_re;
    rd_ctl_d.from_mmio = (tgt == TGT_MMIO);

    if (mmio_wr && reg_off == OFF_SCRATCH) begin
      for (int i = 0; i < 4; i++) begin
        if (dat_we[i]) begin
          scratch_d[8*i +: 8] = dat_wd[8*i +: 8];
        end
      end
    end

    // Only the first DONE write sticks.
    if (mmio_wr && reg_off == OFF_DONE && !done_q) begin
      done_d      = 1'b1;
      done_code_d = dat_wd;
    end

    if (mmio_rd) begin
      case (reg_off)
        OFF_CYCLE:   mmio_rdata_d = cyc_q;
        OFF_CONSOLE: mmio_rdata_d = {27'b0, 3'(con_count), con_full, con_empty};
        OFF_DONE:    mmio_rdata_d = {31'b0, done_q};
        default:     mmio_rdata_d = scratch_q;
      endcase
    end
  end

  // State registers; reset drops any pending read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_q        <= '0;
      scratch_q    <= '0;
      done_q       <= 1'b0;
      done_code_q  <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
      mmio_rdata_q <= '0;
      rd_ctl_q     <= '0;
    end else begin
      cyc_q        <= cyc_d;
      scratch_q    <= scratch_d;
      done_q       <= done_d;
      done_code_q  <= done_code_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
      mmio_rdata_q <= mmio_rdata_d;
      rd_ctl_q     <= rd_ctl_d;
    end
  end

  // Response data: selected source masked to the lanes that were read.
  assign dat_rd    = lane_mask(rd_ctl_q.re) & (rd_ctl_q.from_mmio ? mmio_rdata_q : sram_rd);
  assign done      = done_q;
  assign done_code = done_code_q;
  assign err       = err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp with a behavioural SRAM and a cycle-count reference.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int unsigned AW = 13;

  logic          clk = 1'b0;
  logic          rstn;
  logic [15:0]   dat_a;
  logic [3:0]    dat_we;
  logic [31:0]   dat_wd;
  logic [3:0]    dat_re;
  logic [31:0]   dat_rd;
  logic [AW-1:0] sram_a;
  logic          sram_ce;
  logic [3:0]    sram_we;
  logic [31:0]   sram_wd;
  logic [31:0]   sram_rd = 32'h0;
  logic          con_vld;
  logic [7:0]    con_data;
  logic          con_rdy;
  logic          done;
  logic [31:0]   done_code;
  logic          err;
  logic          ovf;

  int n_tot = 0;
  int n_bad = 0;

  logic [31:0] smem [0:255];
  logic [31:0] ref_cyc;

  always #5 clk = ~clk;

  dmem_resp #(.SRAM_AW(AW), .CON_DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .dat_a     (dat_a),
    .dat_we    (dat_we),
    .dat_wd    (dat_wd),
    .dat_re    (dat_re),
    .dat_rd    (dat_rd),
    .sram_a    (sram_a),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we),
    .sram_wd   (sram_wd),
    .sram_rd   (sram_rd),
    .con_vld   (con_vld),
    .con_data  (con_data),
    .con_rdy   (con_rdy),
    .done      (done),
    .done_code (done_code),
    .err       (err),
    .ovf       (ovf)
  );

  // One-cycle-latency SRAM with byte writes.
  always @(posedge clk) begin
    if (sram_ce) begin
      sram_rd <= smem[sram_a[7:0]];
      for (int i = 0; i < 4; i++) begin
        if (sram_we[i]) smem[sram_a[7:0]][8*i +: 8] <= sram_wd[8*i +: 8];
      end
    end
  end

  // Reference free-running counter.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) ref_cyc <= 32'h0;
    else       ref_cyc <= 32'(ref_cyc + 32'd1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re);
    dat_a  = a;
    dat_we = we;
    dat_wd = wd;
    dat_re = re;
  endtask

  // One request cycle; on return (next falling edge) dat_rd holds its response.
  task automatic step(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic [3:0] re);
    drive(a, we, wd, re);
    @(negedge clk);
    drive(16'h0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic drain(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3);
    logic [7:0] exp [4];
    exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
    con_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_vld", 32'(con_vld), 32'h1);
      check("drain_data", 32'(con_data), 32'(exp[i]));
      @(negedge clk);
    end
    #1;
    check("drain_empty_vld", 32'(con_vld), 32'h0);
    con_rdy = 1'b0;
  endtask

  logic [31:0] exp_c;

  initial begin
    rstn    = 1'b0;
    con_rdy = 1'b0;
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    #3;
    check("rst_dat_rd", dat_rd, 32'h0);
    check("rst_con_vld", 32'(con_vld), 32'h0);
    check("rst_con_data", 32'(con_data), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_done_code", done_code, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // SRAM round trip with combinational macro drive.
    drive(16'h0008, 4'hF, 32'hDEADBEEF, 4'h0);
    #1;
    check("sram_ce_wr", 32'(sram_ce), 32'h1);
    check("sram_a_wr", 32'(sram_a), 32'h2);
    check("sram_we_wr", 32'(sram_we), 32'hF);
    check("sram_wd_wr", sram_wd, 32'hDEADBEEF);
    @(negedge clk);
    drive(16'h0008, 4'h0, 32'h0, 4'h3);
    #1;
    check("sram_a_rd", 32'(sram_a), 32'h2);
    check("sram_we_rd", 32'(sram_we), 32'h0);
    @(negedge clk);
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    check("sram_rd_lo", dat_rd, 32'h0000BEEF);
    step(16'h0008, 4'h0, 32'h0, 4'hC);
    check("sram_rd_hi", dat_rd, 32'hDEAD0000);
    #1;
    check("idle_ce", 32'(sram_ce), 32'h0);
    step(16'h0, 4'h0, 32'h0, 4'h0);
    check("idle_rd", dat_rd, 32'h0);
    drive(16'h800C, 4'hF, 32'h0, 4'h0);
    #1;
    check("mmio_ce", 32'(sram_ce), 32'h0);
    check("mmio_we", 32'(sram_we), 32'h0);
    @(negedge clk);

    // SCRATCH byte-lane writes and aliasing of ignored address bits.
    step(16'h800C, 4'hF, 32'hA5A5A5A5, 4'h0);
    step(16'h800C, 4'h2, 32'h00007700, 4'h0);
    step(16'h800C, 4'h0, 32'h0, 4'hF);
    check("scratch_rd", dat_rd, 32'hA5A577A5);
    step(16'hFFFC, 4'h0, 32'h0, 4'hF);
    check("scratch_alias", dat_rd, 32'hA5A577A5);

    // CYCLE counter reads and ignored writes.
    exp_c = ref_cyc;
    step(16'h8000, 4'h0, 32'h0, 4'hF);
    check("cycle_rd", dat_rd, exp_c);
    exp_c = ref_cyc;
    step(16'h8000, 4'h0, 32'h0, 4'h1);
    check("cycle_rd_lane0", dat_rd, exp_c & 32'hFF);
    step(16'h8000, 4'hF, 32'h0, 4'h0);
    exp_c = ref_cyc;
    step(16'h8000, 4'h0, 32'h0, 4'hF);
    check("cycle_wr_ignored", dat_rd, exp_c);

    // Console: empty status, upper-lane write does not push.
    step(16'h8004, 4'h0, 32'h0, 4'hF);
    check("con_empty_stat", dat_rd, 32'h01);
    step(16'h8004, 4'h2, 32'h99, 4'h0);
    step(16'h8004, 4'h0, 32'h0, 4'hF);
    check("con_lane1_nopush", dat_rd, 32'h01);

    // Full FIFO with simultaneous push and pop.
    step(16'h8004, 4'h1, 32'h61, 4'h0);
    step(16'h8004, 4'h1, 32'h62, 4'h0);
    step(16'h8004, 4'h1, 32'h63, 4'h0);
    step(16'h8004, 4'h1, 32'h64, 4'h0);
    step(16'h8004, 4'h0, 32'h0, 4'hF);
    check("con_full_stat", dat_rd, 32'h12);
    check("con_full_ovf", 32'(ovf), 32'h0);
    check("con_head_hold", 32'(con_data), 32'h61);
    con_rdy = 1'b1;
    step(16'h8004, 4'h1, 32'h55, 4'h0);
    con_rdy = 1'b0;
    step(16'h8004, 4'h0, 32'h0, 4'hF);
    check("con_pushpop_stat", dat_rd, 32'h12);
    check("con_pushpop_ovf", 32'(ovf), 32'h0);
    drain(8'h62, 8'h63, 8'h64, 8'h55);

    // Overflow: fifth push dropped.
    step(16'h8004, 4'h1, 32'h41, 4'h0);
    step(16'h8004, 4'h1, 32'h42, 4'h0);
    step(16'h8004, 4'h1, 32'h43, 4'h0);
    step(16'h8004, 4'h1, 32'h44, 4'h0);
    step(16'h8004, 4'h1, 32'h45, 4'h0);
    check("con_ovf", 32'(ovf), 32'h1);
    step(16'h8004, 4'h0, 32'h0, 4'hF);
    check("con_ovf_stat", dat_rd, 32'h12);
    drain(8'h41, 8'h42, 8'h43, 8'h44);

    // DONE: first write wins.
    step(16'h8008, 4'hF, 32'h1, 4'h0);
    check("done_set", 32'(done), 32'h1);
    check("done_code1", done_code, 32'h1);
    step(16'h8008, 4'hF, 32'h2, 4'h0);
    check("done_still", 32'(done), 32'h1);
    check("done_code_kept", done_code, 32'h1);
    step(16'h8008, 4'h0, 32'h0, 4'hF);
    check("done_rd", dat_rd, 32'h1);

    // Protocol error: write happens, read suppressed.
    check("err_before", 32'(err), 32'h0);
    step(16'h800C, 4'hF, 32'h12345678, 4'hF);
    check("perr_rd", dat_rd, 32'h0);
    check("perr_err", 32'(err), 32'h1);
    step(16'h800C, 4'h0, 32'h0, 4'hF);
    check("perr_scratch", dat_rd, 32'h12345678);

    // Reset in the middle of traffic.
    step(16'h8004, 4'h1, 32'h31, 4'h0);
    step(16'h8004, 4'h1, 32'h32, 4'h0);
    drive(16'h800C, 4'h0, 32'h0, 4'hF);
    @(posedge clk);
    #1;
    drive(16'h0, 4'h0, 32'h0, 4'h0);
    check("inflight_rd", dat_rd, 32'h12345678);
    check("inflight_vld", 32'(con_vld), 32'h1);
    rstn = 1'b0;
    #1;
    check("mid_rst_rd", dat_rd, 32'h0);
    check("mid_rst_vld", 32'(con_vld), 32'h0);
    check("mid_rst_data", 32'(con_data), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_code", done_code, 32'h0);
    check("mid_rst_ovf", 32'(ovf), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(16'h0, 4'h0, 32'h0, 4'h0);
    step(16'h8000, 4'h0, 32'h0, 4'hF);
    check("post_rst_cycle", dat_rd, 32'h1);
    check("post_rst_vld", 32'(con_vld), 32'h0);
    step(16'h800C, 4'h0, 32'h0, 4'hF);
    check("post_rst_scratch", dat_rd, 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
